// File: rtl/recetor_serie_paridade_pkg.sv
// Shared definitions for the serial parity receiver:
// FSM state encoding and frame-layout constants.
package recetor_serie_paridade_pkg;

    typedef enum logic [2:0] {
        REPOUSO  = 3'd0,
        INICIO   = 3'd1,
        DADOS    = 3'd2,
        PARIDADE = 3'd3,
        PARAGEM  = 3'd4
    } estado_t;

    localparam int NBITS_DADOS = 4;
    localparam int NBITS_TRAMA = 7;

endpackage

// File: rtl/recetor_serie_paridade_sincronizador_rx.sv
// Two-flop synchroniser for the asynchronous RX line plus a
// registered falling-edge detector on the synchronised signal.
// Ports: clk, rst (sync, active high), rx (async line),
//        rx_sinc (synchronised line), desc_rx (falling edge seen).
module sincronizador_rx (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_sinc,
    output logic desc_rx
);

    logic s1;
    logic s2;
    logic s3;

    // All three flops reset high so that an idle line produces no edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= rx;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rx_sinc = s2;
    assign desc_rx = s3 & ~s2;

endmodule

// File: rtl/recetor_serie_paridade.sv
// Serial receiver for a 4-bit nibble plus parity bit
// (start 0, D0..D3 LSB first, parity, stop 1; idle high).
// Ports: CLK, RST (sync, active high), RX (async line),
//        D/P (received nibble and parity bit), VALIDO (one-cycle
//        update pulse), ERRO_PAR, ERRO_TRAMA, OCUPADO (frame busy).
module recetor_serie_paridade
    import recetor_serie_paridade_pkg::*;
#(
    parameter int   CICLOS_BIT = 16,
    parameter logic PAR_IMPAR  = 1'b0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RX,
    output logic [NBITS_DADOS-1:0] D,
    output logic                   P,
    output logic                   VALIDO,
    output logic                   ERRO_PAR,
    output logic                   ERRO_TRAMA,
    output logic                   OCUPADO
);

    localparam int TW = $clog2(CICLOS_BIT);
    localparam logic [TW-1:0] T_MEIO = TW'(CICLOS_BIT / 2 - 1);
    localparam logic [TW-1:0] T_BIT  = TW'(CICLOS_BIT - 1);
    localparam logic [1:0]    ULTIMO = 2'(NBITS_DADOS - 1);

    estado_t                estado;
    estado_t                estado_prox;
    logic [TW-1:0]          timer;
    logic [1:0]             bit_cnt;
    logic [NBITS_DADOS-1:0] sr;
    logic                   p_amostra;
    logic                   stop_amostra;
    logic                   fim;
    logic                   rx_sinc;
    logic                   desc_rx;
    logic                   meio_bit;
    logic                   fim_bit;

    sincronizador_rx u_sinc (
        .clk     (CLK),
        .rst     (RST),
        .rx      (RX),
        .rx_sinc (rx_sinc),
        .desc_rx (desc_rx)
    );

    assign meio_bit = (timer == T_MEIO);
    assign fim_bit  = (timer == T_BIT);
    assign OCUPADO  = (estado != REPOUSO);

    always_ff @(posedge CLK) begin
        if (RST) estado <= REPOUSO;
        else     estado <= estado_prox;
    end

    always_comb begin
        estado_prox = estado;
        unique case (estado)
            REPOUSO: begin
                if (desc_rx) estado_prox = INICIO;
            end
            INICIO: begin
                if (meio_bit)
                    estado_prox = rx_sinc ? REPOUSO : DADOS;
            end
            DADOS: begin
                if (fim_bit && bit_cnt == ULTIMO)
                    estado_prox = PARIDADE;
            end
            PARIDADE: begin
                if (fim_bit) estado_prox = PARAGEM;
            end
            PARAGEM: begin
                if (fim) estado_prox = REPOUSO;
            end
            default: estado_prox = REPOUSO;
        endcase
    end

    // The edge-detect cycle counts as timer 0, so the timer enters
    // INICIO at 1; the start mid-sample then lands N/2-1 edges later.
    // In PARAGEM the stop bit is captured first and the outputs are
    // published one cycle later (fim), which is when VALIDO pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            timer        <= '0;
            bit_cnt      <= '0;
            sr           <= '0;
            p_amostra    <= 1'b0;
            stop_amostra <= 1'b1;
            fim          <= 1'b0;
            D            <= '0;
            P            <= 1'b0;
            VALIDO       <= 1'b0;
            ERRO_PAR     <= 1'b0;
            ERRO_TRAMA   <= 1'b0;
        end else begin
            VALIDO <= 1'b0;
            case (estado)
                REPOUSO: begin
                    timer   <= desc_rx ? TW'(1) : '0;
                    bit_cnt <= '0;
                    fim     <= 1'b0;
                end
                INICIO: begin
                    timer <= meio_bit ? '0 : timer + 1'b1;
                end
                DADOS: begin
                    timer <= fim_bit ? '0 : timer + 1'b1;
                    if (fim_bit) begin
                        sr      <= {rx_sinc, sr[NBITS_DADOS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                PARIDADE: begin
                    timer <= fim_bit ? '0 : timer + 1'b1;
                    if (fim_bit) p_amostra <= rx_sinc;
                end
                PARAGEM: begin
                    timer <= fim_bit ? '0 : timer + 1'b1;
                    if (fim_bit && !fim) begin
                        stop_amostra <= rx_sinc;
                        fim          <= 1'b1;
                    end
                    if (fim) begin
                        D          <= sr;
                        P          <= p_amostra;
                        ERRO_PAR   <= ^{sr, p_amostra} ^ PAR_IMPAR;
                        ERRO_TRAMA <= ~stop_amostra;
                        VALIDO     <= 1'b1;
                        fim        <= 1'b0;
                    end
                end
                default: begin
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/recetor_serie_paridade.md
# recetor_serie_paridade

Serial frame receiver that deserialises a 4-bit data nibble plus one parity bit from a single asynchronous line. It presents the nibble, the received parity bit and error flags to the downstream nibble parity-check stage. It sits between the board's serial input pin and the 4-bit parity checker, and also flags parity errors locally. Frame format: 1 start bit (0), D0..D3 LSB first, 1 parity bit, 1 stop bit (1); the line idles high.

## Interface
- CICLOS_BIT, 16, CLK cycles per serial bit; even, ≥ 4.
- PAR_IMPAR, 0, 0 = even parity (valid when ^{D,P} == 0); 1 = odd parity (valid when ^{D,P} == 1).

- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- RX  in  1  asynchronous serial line, idle high.
- D  out  4  received nibble, D[0] = first data bit.
- P  out  1  received parity bit.
- VALIDO  out  1  one-cycle pulse: D, P and the error flags were just updated.
- ERRO_PAR  out  1  parity mismatch on the last frame.
- ERRO_TRAMA  out  1  stop bit sampled 0 on the last frame.
- OCUPADO  out  1  high while a frame is being received (state ≠ REPOUSO).

## Operation
- RX passes through a 2-flop synchroniser (reset value 1,1), then a falling-edge detector on the synchronised signal.
- FSM states: REPOUSO, INICIO, DADOS, PARIDADE, PARAGEM.
  - REPOUSO → INICIO on a detected falling edge. The bit-timer resets to 0.
  - INICIO: at the half-bit point (timer = CICLOS_BIT/2 − 1), sample the line.
    - Sample 1 = false start → REPOUSO, with no VALIDO.
    - Sample 0 → DADOS; the timer restarts.
  - DADOS: sample every CICLOS_BIT cycles into a shift register, LSB first. A 2-bit counter selects the bit; → PARIDADE after D3.
  - PARIDADE: one sample after CICLOS_BIT cycles; → PARAGEM.
  - PARAGEM: one sample after CICLOS_BIT cycles.
    - Register D, P, ERRO_PAR = ^{D,P} ^ PAR_IMPAR, and ERRO_TRAMA = ~stop.
    - Pulse VALIDO; → REPOUSO.
- A frame with a stop error still updates D/P, pulses VALIDO and sets ERRO_TRAMA.
- The edge detector needs the synchronised line to return high before a new frame starts. A line stuck low therefore produces exactly one frame.
- Falling edges on RX while OCUPADO = 1 are ignored.
- D, P, ERRO_PAR and ERRO_TRAMA hold their values until the next VALIDO.

## Timing
- Reset values: D = 0, P = 0, VALIDO = 0, ERRO_PAR = 0, ERRO_TRAMA = 0, OCUPADO = 0. FSM = REPOUSO, timer = 0, synchroniser = 1,1.
- RST has priority over everything, mid-frame included. The partial frame is discarded and no VALIDO is emitted.
- Let k0 be the CLK edge at which the first synchroniser flop first captures RX = 0. Let N = CICLOS_BIT.
  - OCUPADO rises at edge k0+2.
  - Start sample is taken at edge k0+1+N/2.
  - Bit i is sampled at edge k0+1+N/2+i·N, for i = 1..4 (D0..D3), 5 (P), 6 (stop).
  - VALIDO is high for exactly the cycle after edge k0+2+N/2+6N. D, P and the flags are valid in that same cycle.
  - OCUPADO falls together with the VALIDO rise.
  - With N = 16: VALIDO is registered at edge k0+106.
- Earliest back-to-back start: the next falling edge may occur any time after the stop bit's mid-sample. Its first capture can then be in the cycle VALIDO is high, and it is accepted.
- Bit-timer width: $clog2(CICLOS_BIT). It wraps to 0 at each sample; no overflow is possible.

## Structure
- Shared package:
  - FSM state encoding (3-bit, five states);
  - frame-layout constants: NBITS_DADOS = 4, frame length 7 bits.
- One sub-module: sincronizador_rx. It holds the 2-flop synchroniser plus the registered falling-edge detector; outputs are rx_sinc and desc_rx.
- Parity is an inline XOR reduction; no separate instance is needed.

## Test plan
- N = 16, PAR_IMPAR = 0: send D = 1011 (line bits 0,1,1,0,1,P=1,1) → one VALIDO at k0+106; D = 1011, P = 1, ERRO_PAR = 0, ERRO_TRAMA = 0.
- Same frame with P = 0 → D = 1011, ERRO_PAR = 1, ERRO_TRAMA = 0. Then a PAR_IMPAR = 1 build with P = 0 → ERRO_PAR = 0.
- Send D = 0110, P = 0, stop = 0 → VALIDO once, ERRO_TRAMA = 1, ERRO_PAR = 0. Hold RX low for another 200 cycles → no second VALIDO.
- RX low for 3 cycles, then high → OCUPADO pulses, returns to REPOUSO, and VALIDO never asserts.
- Assert RST for 1 cycle at k0+50 mid-frame → all outputs at reset values next cycle; no VALIDO. A following clean frame with D = 0001 is received correctly.
- Two back-to-back frames, D = 1111 then D = 0000, with the second start bit immediately after the first stop bit → two VALIDO pulses 7·16 cycles apart, with correct nibbles and no errors.
